// File: rtl/sdpram_be_clr.sv
// Single-clock simple dual-port RAM with per-byte write enables and optional output stage.
// Same-address read/write is write-first or read-first, and the array can be zeroed after reset.
module sdpram_be_clr #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int BYTE_SIZE      = 8,
    parameter int OUTPUT_REG     = 0,
    parameter int BYPASS         = 1,
    parameter int CLEAR_ON_RESET = 1,
    localparam int BE_WIDTH      = DATA_WIDTH / BYTE_SIZE,
    localparam int DEPTH         = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [BE_WIDTH-1:0]   wr_byte_en,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  init_busy
);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t                  state_reg;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   clr_cnt_reg;
    logic                    clr_active;
    logic                    wr_fire;
    logic                    rd_fire;
    logic                    bypass_hit;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [BE_WIDTH-1:0]     lane_we;
    logic [ADDR_WIDTH-1:0]   mem_waddr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [DATA_WIDTH-1:0]   rd_word;
    logic [DATA_WIDTH-1:0]   rd_merged;

    logic [DATA_WIDTH-1:0]   s1_data_reg;
    logic                    s1_valid_reg;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: leave CLEAR on the edge that zeroes the last word
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            CLEAR: if (clr_cnt_reg == ADDR_WIDTH'(DEPTH - 1)) state_next = READY;
            READY: state_next = READY;
            default: state_next = READY;
        endcase
    end

    // Output logic: requests are only honoured once the array is ready
    always_comb begin
        init_busy  = 1'b0;
        clr_active = 1'b0;
        wr_fire    = 1'b0;
        rd_fire    = 1'b0;
        case (state_reg)
            CLEAR: begin
                init_busy  = 1'b1;
                clr_active = 1'b1;
            end
            READY: begin
                wr_fire = wr_en;
                rd_fire = rd_en;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_cnt_reg <= '0;
        end else if (clr_active) begin
            clr_cnt_reg <= clr_cnt_reg + 1'b1;
        end
    end

    // The clear sweep shares the single write port with normal writes
    assign mem_waddr = clr_active ? clr_cnt_reg : wr_addr;
    assign mem_wdata = clr_active ? '0 : wr_data;
    assign rd_word   = mem[rd_addr];
    assign bypass_hit = (BYPASS != 0) && wr_fire && rd_fire && (wr_addr == rd_addr);

    genvar gi;
    generate
        for (gi = 0; gi < BE_WIDTH; gi++) begin : g_lane
            assign lane_we[gi] = clr_active | (wr_fire & wr_byte_en[gi]);
            // Write-first merge: only lanes actually being written take the new bytes
            assign rd_merged[gi*BYTE_SIZE +: BYTE_SIZE] =
                (bypass_hit && wr_byte_en[gi]) ? wr_data[gi*BYTE_SIZE +: BYTE_SIZE]
                                               : rd_word[gi*BYTE_SIZE +: BYTE_SIZE];
        end
    endgenerate

    // Array is deliberately not reset; only control and output state are
    always_ff @(posedge clk) begin
        for (int i = 0; i < BE_WIDTH; i++) begin
            if (lane_we[i]) begin
                mem[mem_waddr][i*BYTE_SIZE +: BYTE_SIZE] <= mem_wdata[i*BYTE_SIZE +: BYTE_SIZE];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_data_reg  <= '0;
            s1_valid_reg <= 1'b0;
        end else begin
            s1_valid_reg <= rd_fire;
            if (rd_fire) s1_data_reg <= rd_merged;
        end
    end

    generate
        if (OUTPUT_REG != 0) begin : g_oreg
            logic [DATA_WIDTH-1:0] s2_data_reg;
            logic                  s2_valid_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s2_data_reg  <= '0;
                    s2_valid_reg <= 1'b0;
                end else begin
                    s2_valid_reg <= s1_valid_reg;
                    if (s1_valid_reg) s2_data_reg <= s1_data_reg;
                end
            end

            assign rd_data  = s2_data_reg;
            assign rd_valid = s2_valid_reg;
        end else begin : g_no_oreg
            assign rd_data  = s1_data_reg;
            assign rd_valid = s1_valid_reg;
        end
    endgenerate

endmodule

// File: tb/tb_sdpram_be_clr.sv
// Directed bench: four RAM instances (write-first, read-first, output-registered, 9-bit bytes)
// sharing one clock and reset, each exercised by its own scenario task.
module tb_sdpram_be_clr;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Index 0: default, 1: BYPASS=0, 2: OUTPUT_REG=1
    logic        wr_en      [3];
    logic [7:0]  wr_addr    [3];
    logic [31:0] wr_data    [3];
    logic [3:0]  wr_byte_en [3];
    logic        rd_en      [3];
    logic [7:0]  rd_addr    [3];
    logic [31:0] rd_data    [3];
    logic        rd_valid   [3];
    logic        init_busy  [3];

    logic        b9_wr_en, b9_rd_en, b9_rd_valid, b9_init_busy;
    logic [7:0]  b9_wr_addr, b9_rd_addr;
    logic [35:0] b9_wr_data, b9_rd_data;
    logic [3:0]  b9_wr_byte_en;

    int checks = 0;
    int errors = 0;

    sdpram_be_clr u_wf (
        .clk(clk), .rst(rst), .wr_en(wr_en[0]), .wr_addr(wr_addr[0]), .wr_data(wr_data[0]),
        .wr_byte_en(wr_byte_en[0]), .rd_en(rd_en[0]), .rd_addr(rd_addr[0]),
        .rd_data(rd_data[0]), .rd_valid(rd_valid[0]), .init_busy(init_busy[0])
    );

    sdpram_be_clr #(.BYPASS(0)) u_rf (
        .clk(clk), .rst(rst), .wr_en(wr_en[1]), .wr_addr(wr_addr[1]), .wr_data(wr_data[1]),
        .wr_byte_en(wr_byte_en[1]), .rd_en(rd_en[1]), .rd_addr(rd_addr[1]),
        .rd_data(rd_data[1]), .rd_valid(rd_valid[1]), .init_busy(init_busy[1])
    );

    sdpram_be_clr #(.OUTPUT_REG(1)) u_oreg (
        .clk(clk), .rst(rst), .wr_en(wr_en[2]), .wr_addr(wr_addr[2]), .wr_data(wr_data[2]),
        .wr_byte_en(wr_byte_en[2]), .rd_en(rd_en[2]), .rd_addr(rd_addr[2]),
        .rd_data(rd_data[2]), .rd_valid(rd_valid[2]), .init_busy(init_busy[2])
    );

    sdpram_be_clr #(.BYTE_SIZE(9), .DATA_WIDTH(36)) u_b9 (
        .clk(clk), .rst(rst), .wr_en(b9_wr_en), .wr_addr(b9_wr_addr), .wr_data(b9_wr_data),
        .wr_byte_en(b9_wr_byte_en), .rd_en(b9_rd_en), .rd_addr(b9_rd_addr),
        .rd_data(b9_rd_data), .rd_valid(b9_rd_valid), .init_busy(b9_init_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int i, input logic [7:0] a, input logic [31:0] d, input logic [3:0] b);
        wr_en[i] = 1'b1; wr_addr[i] = a; wr_data[i] = d; wr_byte_en[i] = b;
        tick();
        wr_en[i] = 1'b0;
    endtask

    task automatic rd(input int i, input logic [7:0] a);
        rd_en[i] = 1'b1; rd_addr[i] = a;
        tick();
        rd_en[i] = 1'b0;
    endtask

    // Counts edges while busy, bounded so a stuck clear cannot hang the run
    task automatic wait_ready(output int n);
        n = 0;
        while (init_busy[0] && n < 1000) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        int n;
        checks++;
        if (init_busy[0] !== 1'b1 || rd_valid[0] !== 1'b0 || rd_data[0] !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: busy=%b valid=%b data=%h, required busy=1 valid=0 data=0",
                     init_busy[0], rd_valid[0], rd_data[0]);
        end
        tick(); tick(); tick();
        rst = 1'b0;
        wait_ready(n);
        checks++;
        if (n != 256) begin
            errors++;
            $display("FAIL first_clear_len: got %0d edges, required 256", n);
        end
        checks++;
        if (b9_init_busy !== 1'b0) begin
            errors++;
            $display("FAIL b9_ready: busy=%b, required 0", b9_init_busy);
        end
    endtask

    task automatic test_clear();
        int n;
        int saw;
        wr(0, 8'h10, 32'hDEADBEEF, 4'hF);
        rd(0, 8'h10);
        checks++;
        if (rd_valid[0] !== 1'b1 || rd_data[0] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL preload_read: valid=%b data=%h, required 1 deadbeef", rd_valid[0], rd_data[0]);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (init_busy[0] !== 1'b1 || rd_valid[0] !== 1'b0 || rd_data[0] !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: busy=%b valid=%b data=%h, required 1 0 0",
                     init_busy[0], rd_valid[0], rd_data[0]);
        end
        tick(); tick(); tick();
        rst = 1'b0;
        n = 0;
        saw = 0;
        while (init_busy[0] && n < 1000) begin
            wr_en[0] = n[0]; wr_addr[0] = 8'h10; wr_data[0] = 32'hDEADBEEF; wr_byte_en[0] = 4'hF;
            rd_en[0] = n[0]; rd_addr[0] = 8'h10;
            tick();
            n++;
            if (rd_valid[0]) saw++;
        end
        wr_en[0] = 1'b0;
        rd_en[0] = 1'b0;
        checks++;
        if (n != 256) begin
            errors++;
            $display("FAIL clear_len: got %0d edges, required 256", n);
        end
        checks++;
        if (saw != 0) begin
            errors++;
            $display("FAIL busy_ignored: rd_valid seen %0d times, required 0", saw);
        end
        rd(0, 8'h10);
        checks++;
        if (rd_valid[0] !== 1'b1 || rd_data[0] !== 32'h0) begin
            errors++;
            $display("FAIL cleared_0x10: valid=%b data=%h, required 1 00000000", rd_valid[0], rd_data[0]);
        end
        wr(0, 8'h40, 32'h5A5A5A5A, 4'hF);
        rd(0, 8'h40);
        rd(0, 8'h00);
        checks++;
        if (rd_valid[0] !== 1'b1 || rd_data[0] !== 32'h0) begin
            errors++;
            $display("FAIL cleared_0x00: valid=%b data=%h, required 1 00000000", rd_valid[0], rd_data[0]);
        end
        rd(0, 8'h40);
        rd(0, 8'hFF);
        checks++;
        if (rd_valid[0] !== 1'b1 || rd_data[0] !== 32'h0) begin
            errors++;
            $display("FAIL cleared_0xff: valid=%b data=%h, required 1 00000000", rd_valid[0], rd_data[0]);
        end
    endtask

    task automatic test_byte_enables();
        wr(0, 8'h05, 32'h11223344, 4'b1111);
        wr(0, 8'h05, 32'hAABBCCDD, 4'b0101);
        rd_en[0] = 1'b1; rd_addr[0] = 8'h05;
        #1;
        checks++;
        if (rd_valid[0] !== 1'b0) begin
            errors++;
            $display("FAIL be_early_valid: valid=%b before edge, required 0", rd_valid[0]);
        end
        tick();
        rd_en[0] = 1'b0;
        checks++;
        if (rd_valid[0] !== 1'b1 || rd_data[0] !== 32'h11BB33DD) begin
            errors++;
            $display("FAIL be_merge: valid=%b data=%h, required 1 11bb33dd", rd_valid[0], rd_data[0]);
        end
        tick();
        checks++;
        if (rd_valid[0] !== 1'b0 || rd_data[0] !== 32'h11BB33DD) begin
            errors++;
            $display("FAIL be_pulse_hold: valid=%b data=%h, required 0 11bb33dd", rd_valid[0], rd_data[0]);
        end
    endtask

    task automatic test_collision();
        wr(1, 8'h21, 32'h12345678, 4'hF);
        rd(1, 8'h21);
        for (int i = 0; i < 2; i++) begin
            wr_en[i] = 1'b1; wr_addr[i] = 8'h20; wr_data[i] = 32'hCAFEF00D; wr_byte_en[i] = 4'b1100;
            rd_en[i] = 1'b1; rd_addr[i] = 8'h20;
        end
        tick();
        for (int i = 0; i < 2; i++) begin
            wr_en[i] = 1'b0;
            rd_en[i] = 1'b0;
        end
        checks++;
        if (rd_valid[0] !== 1'b1 || rd_data[0] !== 32'hCAFE0000) begin
            errors++;
            $display("FAIL collide_write_first: valid=%b data=%h, required 1 cafe0000", rd_valid[0], rd_data[0]);
        end
        checks++;
        if (rd_valid[1] !== 1'b1 || rd_data[1] !== 32'h0) begin
            errors++;
            $display("FAIL collide_read_first: valid=%b data=%h, required 1 00000000", rd_valid[1], rd_data[1]);
        end
        rd(1, 8'h20);
        checks++;
        if (rd_data[1] !== 32'hCAFE0000) begin
            errors++;
            $display("FAIL read_first_after: data=%h, required cafe0000", rd_data[1]);
        end
        // Different addresses in the same cycle must not interact
        wr_en[0] = 1'b1; wr_addr[0] = 8'h30; wr_data[0] = 32'h87654321; wr_byte_en[0] = 4'hF;
        rd_en[0] = 1'b1; rd_addr[0] = 8'h31;
        tick();
        wr_en[0] = 1'b0;
        rd_en[0] = 1'b0;
        checks++;
        if (rd_data[0] !== 32'h0) begin
            errors++;
            $display("FAIL no_cross_addr: data=%h, required 00000000", rd_data[0]);
        end
        rd(0, 8'h30);
        checks++;
        if (rd_data[0] !== 32'h87654321) begin
            errors++;
            $display("FAIL cross_addr_write: data=%h, required 87654321", rd_data[0]);
        end
    endtask

    task automatic test_back_to_back();
        logic        exp_v;
        logic [31:0] exp_d;
        for (int a = 0; a < 8; a++) wr(2, 8'(a), 32'(a * 3), 4'hF);
        for (int t = 0; t < 11; t++) begin
            rd_en[2] = (t < 8);
            rd_addr[2] = 8'(t);
            tick();
            exp_v = (t >= 1 && t <= 8);
            exp_d = (t >= 8) ? 32'd21 : 32'((t - 1) * 3);
            checks++;
            if (rd_valid[2] !== exp_v) begin
                errors++;
                $display("FAIL stream_valid t=%0d: valid=%b, required %b", t, rd_valid[2], exp_v);
            end
            if (t >= 1) begin
                checks++;
                if (rd_data[2] !== exp_d) begin
                    errors++;
                    $display("FAIL stream_data t=%0d: data=%0d, required %0d", t, rd_data[2], exp_d);
                end
            end
        end
        rd_en[2] = 1'b0;
    endtask

    task automatic test_byte9();
        b9_wr_en = 1'b1; b9_wr_addr = 8'h07; b9_wr_data = 36'hFFFFFFFFF; b9_wr_byte_en = 4'b1000;
        tick();
        b9_wr_en = 1'b0;
        b9_rd_en = 1'b1; b9_rd_addr = 8'h07;
        tick();
        b9_rd_en = 1'b0;
        checks++;
        if (b9_rd_valid !== 1'b1 || b9_rd_data !== 36'hFF8000000) begin
            errors++;
            $display("FAIL byte9_lane3: valid=%b data=%h, required 1 ff8000000", b9_rd_valid, b9_rd_data);
        end
    endtask

    task automatic test_reset_mid_clear();
        int n;
        int bad;
        for (int a = 0; a < 256; a++) wr(0, 8'(a), 32'hFFFFFFFF, 4'hF);
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        for (int k = 0; k < 100; k++) tick();
        checks++;
        if (init_busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL mid_clear_busy: busy=%b at cnt 100, required 1", init_busy[0]);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_ready(n);
        checks++;
        if (n != 256) begin
            errors++;
            $display("FAIL restart_clear_len: got %0d edges, required 256", n);
        end
        bad = 0;
        for (int a = 0; a < 256; a++) begin
            rd(0, 8'(a));
            checks++;
            if (rd_valid[0] !== 1'b1 || rd_data[0] !== 32'h0) begin
                errors++;
                bad++;
                if (bad <= 8)
                    $display("FAIL restart_word 0x%02h: valid=%b data=%h, required 1 00000000",
                             a, rd_valid[0], rd_data[0]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            wr_en[i] = 1'b0; wr_addr[i] = '0; wr_data[i] = '0; wr_byte_en[i] = '0;
            rd_en[i] = 1'b0; rd_addr[i] = '0;
        end
        b9_wr_en = 1'b0; b9_wr_addr = '0; b9_wr_data = '0; b9_wr_byte_en = '0;
        b9_rd_en = 1'b0; b9_rd_addr = '0;
        #1;
        test_reset();
        test_clear();
        test_byte_enables();
        test_collision();
        test_back_to_back();
        test_byte9();
        test_reset_mid_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
